rtc_adapter_tick_gen: RTL and testbench
=======================================

// Module: rtc_adapter_tick_gen
// PURPOSE
// - Multi-channel, runtime-programmable tick/clock generator for the 7-seg adapter and stopwatch timebase.
// - Each channel divides i_sclk by its own divisor D and produces:
//   - a one-cycle strobe, o_tick
//   - a 50%-duty toggle, o_clk, with period 2*D
// - Divisors are reloaded glitch-free through a write port.
// - i_sync phase-aligns all channels at once.
// - Default D=50000 gives a 1 ms o_clk at 100 MHz.
// PARAMETERS
// - NUM_CH       4      number of independent channels (>=1)
// - DIV_WIDTH    16     divisor/counter width
// - DEFAULT_DIV  50000  divisor loaded at reset into every channel (1..2^DIV_WIDTH-1)
// - CH_W         $clog2(NUM_CH) min 1 (localparam)
// PORTS
// - i_sclk     in   1          system clock, all logic on rising edge
// - i_reset_n  in   1          asynchronous active-low reset
// - i_en       in   NUM_CH     per-channel enable (level)
// - i_sync     in   1          1-cycle strobe: restart all channels in phase
// - i_wr_en    in   1          1-cycle divisor write strobe
// - i_wr_ch    in   CH_W       target channel of write (>=NUM_CH: write ignored)
// - i_wr_div   in   DIV_WIDTH  new divisor D; 0 clamped to 1
// - o_tick     out  NUM_CH     per-channel 1-cycle strobe, every D cycles
// - o_clk      out  NUM_CH     per-channel toggle output, flips on each tick
// - o_pending  out  NUM_CH     shadow divisor waiting for next wrap
// BEHAVIOUR
// - Reset (async assert, sync release): cnt=0, div=DEFAULT_DIV, shadow=0, o_tick=0, o_clk=0, o_pending=0.
// - Per channel, enabled, each edge:
//   - cnt==div-1: cnt<=0, o_tick<=1, o_clk<=~o_clk
//   - else: cnt<=cnt+1, o_tick<=0
// - o_tick: exactly one cycle high, first on the D-th edge after reset release, enable, or sync; period D thereafter.
// - D=1: o_tick stays high continuously; o_clk toggles every cycle.
// - All outputs are registered; there is no combinational path from inputs to outputs.
// - Disabled (i_en[c]=0): cnt<=0, o_tick<=0, o_clk<=0.
//   - A write to a disabled channel loads div immediately; o_pending stays 0.
// - Write to an enabled channel: shadow<=max(i_wr_div,1), o_pending[c]<=1.
//   - At the next wrap edge (cnt==div-1): div<=shadow, o_pending<=0, and the tick is still issued.
//   - The new period starts from that wrap; no short or long glitch period.
// - A second write while pending overwrites shadow; only the last value applies.
// - i_sync (highest priority over counting): every enabled channel cnt<=0, o_tick<=0, o_clk<=0.
//   - Pending shadows apply immediately at the sync edge; o_pending<=0.
// - i_sync and i_wr_en in the same cycle: the sync takes effect as above, with pendings that existed before that edge applied.
//   - The new write is then captured into shadow with o_pending=1 and applies at the next wrap.
// - Divisor shrink below the current cnt cannot occur, because reload happens only at a wrap.
// - Reset mid-operation: immediate return to reset values; pending writes are lost.
// - Counter arithmetic is DIV_WIDTH bits and never exceeds div-1; no overflow path.
// TESTING
// - Reset release, defaults, i_en=all1 -> o_tick[0] first high on edge 50000, then every 50000; o_clk[0] period 100000 cycles, 50% duty.
// - Write ch1 D=3 while enabled, mid-period (cnt=10 of 50000)
//   -> o_pending[1]=1 until the wrap at edge 50000
//   -> then ticks every 3 cycles; no intermediate tick.
// - Write D=0 to ch2 while i_en[2]=0, then enable -> D clamped to 1; o_tick[2] continuously high from the 1st edge.
// - Channels with D=4 and D=6 free-running, i_sync pulse
//   -> both o_clk=0 and both cnt=0 after the sync edge
//   -> next coincident tick exactly 12 cycles after sync.
// - i_sync and write (ch0, D=5) in the same cycle, with a prior pending D=7 on ch0 -> D=7 active from sync, and o_pending[0]=1 carrying D=5 to the next wrap.
// - Assert i_reset_n=0 asynchronously mid-count with a pending write -> all outputs 0 immediately, no clock edge needed; after release div=DEFAULT_DIV.

Source files
------------

// File: rtl/rtc_adapter_tick_gen.sv
// rtc_adapter_tick_gen: multi-channel programmable tick/clock divider.
// Each channel counts i_sclk edges up to its divisor D. On every wrap it issues
// a one-cycle o_tick and flips o_clk. New divisors wait in a shadow register
// until the next wrap, or until i_sync, so no period is ever cut short.
module rtc_adapter_tick_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_WIDTH   = 16,
  parameter  int DEFAULT_DIV = 50000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 i_sclk,
  input  logic                 i_reset_n,
  input  logic [NUM_CH-1:0]    i_en,
  input  logic                 i_sync,
  input  logic                 i_wr_en,
  input  logic [CH_W-1:0]      i_wr_ch,
  input  logic [DIV_WIDTH-1:0] i_wr_div,
  output logic [NUM_CH-1:0]    o_tick,
  output logic [NUM_CH-1:0]    o_clk,
  output logic [NUM_CH-1:0]    o_pending
);

  logic [DIV_WIDTH-1:0] cnt_r    [NUM_CH];
  logic [DIV_WIDTH-1:0] div_r    [NUM_CH];
  logic [DIV_WIDTH-1:0] shadow_r [NUM_CH];
  logic [NUM_CH-1:0]    wr_hit;
  logic [NUM_CH-1:0]    wrap;
  logic [DIV_WIDTH-1:0] wr_val;

  // Write decode, zero-divisor clamp and per-channel wrap detection.
  // A channel index at or above NUM_CH matches no channel, so the write is dropped.
  always_comb begin
    wr_val = (i_wr_div == '0) ? DIV_WIDTH'(1) : i_wr_div;
    wr_hit = '0;
    wrap   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = i_wr_en && (i_wr_ch == CH_W'(c));
      wrap[c]   = (cnt_r[c] == div_r[c] - DIV_WIDTH'(1));
    end
  end

  // Per-channel counter, divisor reload and registered outputs.
  // A pending shadow is applied before a same-edge write is captured. The write
  // therefore always becomes the next pending value.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_r[c]    <= '0;
        div_r[c]    <= DIV_WIDTH'(DEFAULT_DIV);
        shadow_r[c] <= '0;
      end
      o_tick    <= '0;
      o_clk     <= '0;
      o_pending <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!i_en[c]) begin
          cnt_r[c]     <= '0;
          o_tick[c]    <= 1'b0;
          o_clk[c]     <= 1'b0;
          o_pending[c] <= 1'b0;
          if (wr_hit[c]) begin
            div_r[c] <= wr_val;
          end else if (o_pending[c]) begin
            div_r[c] <= shadow_r[c];
          end
        end else if (i_sync) begin
          cnt_r[c]  <= '0;
          o_tick[c] <= 1'b0;
          o_clk[c]  <= 1'b0;
          if (o_pending[c]) begin
            div_r[c] <= shadow_r[c];
          end
          if (wr_hit[c]) begin
            shadow_r[c]  <= wr_val;
            o_pending[c] <= 1'b1;
          end else begin
            o_pending[c] <= 1'b0;
          end
        end else begin
          if (wrap[c]) begin
            cnt_r[c]  <= '0;
            o_tick[c] <= 1'b1;
            o_clk[c]  <= ~o_clk[c];
            if (o_pending[c]) begin
              div_r[c] <= shadow_r[c];
            end
          end else begin
            cnt_r[c]  <= cnt_r[c] + DIV_WIDTH'(1);
            o_tick[c] <= 1'b0;
          end
          if (wr_hit[c]) begin
            shadow_r[c]  <= wr_val;
            o_pending[c] <= 1'b1;
          end else if (wrap[c]) begin
            o_pending[c] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_adapter_tick_gen.sv
// Bench for rtc_adapter_tick_gen. A small reference model schedules each
// channel's next tick as an absolute edge number. A compare process checks all
// outputs against the model on every falling edge. Directed steps add literal
// expectations at hand-computed edges.
module tb_rtc_adapter_tick_gen;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int DDIV = 100;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            sync;
  logic            wr_en;
  logic [1:0]      wr_ch;
  logic [DW-1:0]   wr_div;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  oclk;
  logic [NCH-1:0]  pend;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  rtc_adapter_tick_gen #(.NUM_CH(NCH), .DIV_WIDTH(DW), .DEFAULT_DIV(DDIV)) dut (
    .i_sclk(clk), .i_reset_n(rst_n), .i_en(en), .i_sync(sync),
    .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_div(wr_div),
    .o_tick(tick), .o_clk(oclk), .o_pending(pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: next tick is an absolute edge number, not a counter.
  int unsigned    edge_n = 0;
  int unsigned    m_div    [NCH];
  int unsigned    m_shadow [NCH];
  int unsigned    m_next   [NCH];
  logic [NCH-1:0] m_tick = '0;
  logic [NCH-1:0] m_clk  = '0;
  logic [NCH-1:0] m_pend = '0;

  always @(posedge clk) begin
    edge_n++;
    for (int c = 0; c < NCH; c++) begin
      automatic bit          w  = wr_en && (int'(wr_ch) == c);
      automatic int unsigned wv = (wr_div == 0) ? 1 : int'(wr_div);
      if (!rst_n) begin
        m_div[c] = DDIV; m_shadow[c] = 0; m_pend[c] = 0;
        m_tick[c] = 0; m_clk[c] = 0;
        m_next[c] = edge_n + m_div[c];
      end else if (!en[c]) begin
        if (m_pend[c]) m_div[c] = m_shadow[c];
        m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        if (w) m_div[c] = wv;
        m_next[c] = edge_n + m_div[c];
      end else if (sync) begin
        if (m_pend[c]) m_div[c] = m_shadow[c];
        m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        m_next[c] = edge_n + m_div[c];
        if (w) begin m_shadow[c] = wv; m_pend[c] = 1; end
      end else begin
        if (edge_n == m_next[c]) begin
          m_tick[c] = 1;
          m_clk[c]  = ~m_clk[c];
          if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 0; end
          m_next[c] = edge_n + m_div[c];
        end else begin
          m_tick[c] = 0;
        end
        if (w) begin m_shadow[c] = wv; m_pend[c] = 1; end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_clk",  32'(oclk), 32'(m_clk));
      chk("model_pend", 32'(pend), 32'(m_pend));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_div = DW'(d);
  endtask

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    step(3);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_clk",  32'(oclk), 0);
    chk("reset_pend", 32'(pend), 0);

    // Release with ch2 disabled; edges are now numbered from 1.
    rst_n = 1'b1; en = 4'b1011;
    step(10);
    wr(1, 3);                  // write lands on edge 11, cnt = 10
    step(1); wr_en = 1'b0;
    chk("wr_en_pending1", 32'(pend[1]), 1);
    wr(2, 0);                  // disabled channel, value 0 clamps to 1
    step(1); wr_en = 1'b0;
    chk("wr_dis_no_pend", 32'(pend[2]), 0);
    step(87);                  // edge 99
    chk("tick0_e99",  32'(tick[0]), 0);
    chk("tick1_e99",  32'(tick[1]), 0);
    chk("pend1_e99",  32'(pend[1]), 1);
    step(1);                   // edge 100
    chk("tick0_e100", 32'(tick[0]), 1);
    chk("clk0_e100",  32'(oclk[0]), 1);
    chk("tick1_e100", 32'(tick[1]), 1);
    chk("pend1_e100", 32'(pend[1]), 0);
    step(2);
    chk("tick1_e102", 32'(tick[1]), 0);
    step(1);
    chk("tick1_e103", 32'(tick[1]), 1);
    step(97);                  // edge 200
    chk("tick0_e200", 32'(tick[0]), 1);
    chk("clk0_e200",  32'(oclk[0]), 0);

    // Enable ch2 with D=1.
    en = 4'b1111;
    step(1);                   // edge 201
    chk("d1_tick_e1", 32'(tick[2]), 1);
    chk("d1_clk_e1",  32'(oclk[2]), 1);
    wr(0, 4);
    step(1);                   // edge 202
    chk("d1_tick_e2", 32'(tick[2]), 1);
    chk("d1_clk_e2",  32'(oclk[2]), 0);
    wr(3, 6);
    step(1); wr_en = 1'b0;     // edge 203
    chk("pend_0_3",   32'(pend), 32'b1001);
    step(97);                  // edge 300: both reload at wrap
    chk("pend_e300",  32'(pend & 4'b1001), 0);
    chk("tick_e300",  32'(tick & 4'b1001), 32'b1001);

    // Sync with D=4 (ch0) and D=6 (ch3).
    step(7);
    sync = 1'b1;
    step(1); sync = 1'b0;      // edge 308
    chk("sync_tick",  32'(tick & 4'b1001), 0);
    chk("sync_clk",   32'(oclk & 4'b1001), 0);
    step(11);                  // edge 319
    chk("sync_e319",  32'(tick & 4'b1001), 0);
    step(1);                   // edge 320, 12 after sync
    chk("sync_e320",  32'(tick & 4'b1001), 32'b1001);

    // Pending D=7, then sync together with a write of D=5.
    wr(0, 7);
    step(1);                   // edge 321
    sync = 1'b1; wr(0, 5);
    step(1); sync = 1'b0; wr_en = 1'b0;   // edge 322
    chk("sw_pend0",   32'(pend[0]), 1);
    chk("sw_clk0",    32'(oclk[0]), 0);
    step(6);                   // edge 328
    chk("sw_e328",    32'(tick[0]), 0);
    step(1);                   // edge 329: D=7 from sync
    chk("sw_e329",    32'(tick[0]), 1);
    chk("sw_pend_e329", 32'(pend[0]), 0);
    step(5);                   // edge 334: D=5 now active
    chk("sw_e334",    32'(tick[0]), 1);

    // Asynchronous reset with a pending write.
    wr(1, 9);
    step(1); wr_en = 1'b0;
    chk("rst_pre_pend", 32'(pend[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tick", 32'(tick), 0);
    chk("async_clk",  32'(oclk), 0);
    chk("async_pend", 32'(pend), 0);
    step(1);
    rst_n = 1'b1;
    step(99);
    chk("post_rst_e99",  32'(tick), 0);
    step(1);
    chk("post_rst_e100", 32'(tick), 32'b1111);
    chk("post_rst_pend", 32'(pend), 0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
